// File: rtl/lsu_arbiter.sv
// Two-port load/store request arbiter: a 2-entry FIFO per requester feeding one
// LSU issue port, with round-robin or fixed priority and tagged completion routing.
module lsu_arbiter #(
    parameter bit PRIO_RR = 1'b1
) (
    input  logic        clk,
    input  logic        a_rst,

    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_data,
    input  logic        p0_width,
    input  logic        p0_cmd,
    output logic        p0_done,
    output logic        p0_done_seq,

    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_data,
    input  logic        p1_width,
    input  logic        p1_cmd,
    output logic        p1_done,
    output logic        p1_done_seq,

    output logic [15:0] rq_addr,
    output logic [15:0] rq_data,
    output logic        rq_width,
    output logic        rq_cmd,
    output logic [1:0]  rq_tag,
    output logic        rq_start,
    input  logic        rq_hold,

    input  logic        rs_wb,
    input  logic [1:0]  rs_tag
);

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned NP    = 2;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          width;
        logic          cmd;
        logic          seq;
    } entry_t;

    entry_t          mem [NP][DEPTH];
    entry_t          in_entry [NP];
    logic [CW-1:0]   count [NP];
    logic [NP-1:0]   rd_ptr;
    logic [NP-1:0]   wr_ptr;
    logic [NP-1:0]   seq_cnt;
    logic [NP-1:0]   push;
    logic [NP-1:0]   pop;
    logic [NP-1:0]   non_empty;
    logic [NP-1:0]   full;
    logic            grant_c;
    logic            last_grant;
    entry_t          head;

    assign in_entry[0] = '{addr: p0_addr, data: p0_data, width: p0_width, cmd: p0_cmd, seq: seq_cnt[0]};
    assign in_entry[1] = '{addr: p1_addr, data: p1_data, width: p1_width, cmd: p1_cmd, seq: seq_cnt[1]};

    // FIFO status comes only from registered counts, so a pop never frees a slot in the same cycle
    always_comb begin
        non_empty = '0;
        full      = '0;
        for (int n = 0; n < int'(NP); n++) begin
            non_empty[n] = (count[n] != '0);
            full[n]      = (count[n] == CW'(DEPTH));
        end
    end

    assign p0_ready = ~full[0];
    assign p1_ready = ~full[1];
    assign push[0]  = p0_valid & ~full[0];
    assign push[1]  = p1_valid & ~full[1];

    // Arbitration: lone requester wins; on contention alternate or favour port 0
    always_comb begin
        grant_c = 1'b0;
        if (non_empty[0] && non_empty[1]) begin
            grant_c = PRIO_RR ? ~last_grant : 1'b0;
        end else if (non_empty[1]) begin
            grant_c = 1'b1;
        end
    end

    assign rq_start = ~rq_hold & (|non_empty);
    assign pop[0]   = rq_start & ~grant_c;
    assign pop[1]   = rq_start & grant_c;

    assign head     = mem[grant_c][rd_ptr[grant_c]];
    assign rq_addr  = head.addr;
    assign rq_data  = head.data;
    assign rq_width = head.width;
    assign rq_cmd   = head.cmd;
    assign rq_tag   = {grant_c, head.seq};

    // Entry storage carries no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        for (int n = 0; n < int'(NP); n++) begin
            if (push[n]) begin
                mem[n][wr_ptr[n]] <= in_entry[n];
            end
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            seq_cnt <= '0;
            for (int n = 0; n < int'(NP); n++) begin
                count[n] <= '0;
            end
        end else begin
            for (int n = 0; n < int'(NP); n++) begin
                if (push[n]) begin
                    wr_ptr[n]  <= ~wr_ptr[n];
                    seq_cnt[n] <= ~seq_cnt[n];
                end
                if (pop[n]) begin
                    rd_ptr[n] <= ~rd_ptr[n];
                end
                if (push[n] && !pop[n]) begin
                    count[n] <= count[n] + CW'(1);
                end else if (pop[n] && !push[n]) begin
                    count[n] <= count[n] - CW'(1);
                end
            end
        end
    end

    // Reset value 1 makes port 0 win the first contention
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            last_grant <= 1'b1;
        end else if (rq_start) begin
            last_grant <= grant_c;
        end
    end

    // Completion pulse is steered to the port encoded in the tag's upper bit
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            p0_done     <= 1'b0;
            p1_done     <= 1'b0;
            p0_done_seq <= 1'b0;
            p1_done_seq <= 1'b0;
        end else begin
            p0_done     <= rs_wb & ~rs_tag[1];
            p1_done     <= rs_wb &  rs_tag[1];
            p0_done_seq <= rs_wb & ~rs_tag[1] & rs_tag[0];
            p1_done_seq <= rs_wb &  rs_tag[1] & rs_tag[0];
        end
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: round-robin and fixed-priority instances share stimulus;
// expected issues are queued at drive time and popped as rq_start fires.
module tb_lsu_arbiter;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        width;
        logic        cmd;
        logic [1:0]  tag;
    } iss_t;

    typedef struct {
        logic        port;
        logic [15:0] addr;
        logic [15:0] data;
        logic        width;
        logic        cmd;
        logic [1:0]  tag;
    } vec_t;

    typedef struct {
        logic       wb;
        logic [1:0] tag;
        logic       d0;
        logic       s0;
        logic       d1;
        logic       s1;
    } cpl_t;

    logic        clk = 1'b0;
    logic        a_rst;
    logic        p0_valid, p1_valid, p0_width, p1_width, p0_cmd, p1_cmd;
    logic [15:0] p0_addr, p1_addr, p0_data, p1_data;
    logic        rq_hold, rs_wb;
    logic [1:0]  rs_tag;

    logic        rr_p0_ready, rr_p1_ready, rr_p0_done, rr_p1_done, rr_p0_done_seq, rr_p1_done_seq;
    logic [15:0] rr_rq_addr, rr_rq_data;
    logic        rr_rq_width, rr_rq_cmd, rr_rq_start;
    logic [1:0]  rr_rq_tag;
    logic        fp_p0_ready, fp_p1_ready, fp_p0_done, fp_p1_done, fp_p0_done_seq, fp_p1_done_seq;
    logic [15:0] fp_rq_addr, fp_rq_data;
    logic        fp_rq_width, fp_rq_cmd, fp_rq_start;
    logic [1:0]  fp_rq_tag;

    iss_t q_rr[$];
    iss_t q_fp[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lsu_arbiter #(.PRIO_RR(1'b1)) u_rr (
        .clk(clk), .a_rst(a_rst),
        .p0_valid(p0_valid), .p0_ready(rr_p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
        .p0_width(p0_width), .p0_cmd(p0_cmd), .p0_done(rr_p0_done), .p0_done_seq(rr_p0_done_seq),
        .p1_valid(p1_valid), .p1_ready(rr_p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
        .p1_width(p1_width), .p1_cmd(p1_cmd), .p1_done(rr_p1_done), .p1_done_seq(rr_p1_done_seq),
        .rq_addr(rr_rq_addr), .rq_data(rr_rq_data), .rq_width(rr_rq_width), .rq_cmd(rr_rq_cmd),
        .rq_tag(rr_rq_tag), .rq_start(rr_rq_start), .rq_hold(rq_hold),
        .rs_wb(rs_wb), .rs_tag(rs_tag)
    );

    lsu_arbiter #(.PRIO_RR(1'b0)) u_fp (
        .clk(clk), .a_rst(a_rst),
        .p0_valid(p0_valid), .p0_ready(fp_p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
        .p0_width(p0_width), .p0_cmd(p0_cmd), .p0_done(fp_p0_done), .p0_done_seq(fp_p0_done_seq),
        .p1_valid(p1_valid), .p1_ready(fp_p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
        .p1_width(p1_width), .p1_cmd(p1_cmd), .p1_done(fp_p1_done), .p1_done_seq(fp_p1_done_seq),
        .rq_addr(fp_rq_addr), .rq_data(fp_rq_data), .rq_width(fp_rq_width), .rq_cmd(fp_rq_cmd),
        .rq_tag(fp_rq_tag), .rq_start(fp_rq_start), .rq_hold(rq_hold),
        .rs_wb(rs_wb), .rs_tag(rs_tag)
    );

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic iss_t mk(input logic [15:0] a, input logic [15:0] d, input logic w,
                                input logic c, input logic [1:0] t);
        iss_t r;
        r.addr = a; r.data = d; r.width = w; r.cmd = c; r.tag = t;
        return r;
    endfunction

    // Compare one issued request against the head of its expected queue
    task automatic mon_one(input string name, input logic start, input logic [35:0] act, inout iss_t q[$]);
        iss_t e;
        if (start) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: unexpected issue %h, none expected", name, act);
            end else begin
                e = q.pop_front();
                chk(name, act, {e.addr, e.data, e.width, e.cmd, e.tag});
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (a_rst) begin
            mon_one("rr_issue", rr_rq_start, {rr_rq_addr, rr_rq_data, rr_rq_width, rr_rq_cmd, rr_rq_tag}, q_rr);
            mon_one("fp_issue", fp_rq_start, {fp_rq_addr, fp_rq_data, fp_rq_width, fp_rq_cmd, fp_rq_tag}, q_fp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (q_rr.size() != 0 || q_fp.size() != 0); i++) step();
        chk("drain_empty", 36'(q_rr.size() + q_fp.size()), 36'd0);
        step();
        step();
    endtask

    task automatic expect_both(input iss_t e);
        q_rr.push_back(e);
        q_fp.push_back(e);
    endtask

    task automatic idle_inputs();
        p0_valid = 0; p1_valid = 0; p0_addr = '0; p1_addr = '0; p0_data = '0; p1_data = '0;
        p0_width = 0; p1_width = 0; p0_cmd = 0; p1_cmd = 0; rq_hold = 0; rs_wb = 0; rs_tag = '0;
    endtask

    task automatic do_reset();
        a_rst = 1'b0;
        q_rr.delete();
        q_fp.delete();
        step();
        step();
        a_rst = 1'b1;
    endtask

    task automatic drive(input logic port, input logic [15:0] a, input logic [15:0] d,
                         input logic w, input logic c);
        if (port) begin
            p1_valid = 1; p1_addr = a; p1_data = d; p1_width = w; p1_cmd = c;
        end else begin
            p0_valid = 1; p0_addr = a; p0_data = d; p0_width = w; p0_cmd = c;
        end
    endtask

    vec_t tbl[6];
    cpl_t ctb[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 16'h1234, 16'hBEEF, 1'b0, 1'b1, 2'b00};
        tbl[1] = '{1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 2'b01};
        tbl[2] = '{1'b1, 16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 2'b10};
        tbl[3] = '{1'b1, 16'hFFFF, 16'h00FF, 1'b1, 1'b1, 2'b11};
        tbl[4] = '{1'b0, 16'h8000, 16'h1111, 1'b1, 1'b1, 2'b00};
        tbl[5] = '{1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 2'b10};

        ctb[0] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1};
        ctb[1] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
        ctb[2] = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
        ctb[3] = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};

        idle_inputs();
        a_rst = 1'b0;
        #12;
        chk("reset_ready",  36'({rr_p0_ready, rr_p1_ready, fp_p0_ready, fp_p1_ready}), 36'hF);
        chk("reset_start",  36'({rr_rq_start, fp_rq_start}), 36'h0);
        chk("reset_done",   36'({rr_p0_done, rr_p1_done, rr_p0_done_seq, rr_p1_done_seq,
                                 fp_p0_done, fp_p1_done, fp_p0_done_seq, fp_p1_done_seq}), 36'h0);
        do_reset();

        // Single requests one at a time; tags follow the per-port seq toggle
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].port, tbl[i].addr, tbl[i].data, tbl[i].width, tbl[i].cmd);
            expect_both(mk(tbl[i].addr, tbl[i].data, tbl[i].width, tbl[i].cmd, tbl[i].tag));
            #1;
            chk("no_bypass", 36'({rr_rq_start, fp_rq_start}), 36'h0);
            step();
            p0_valid = 0;
            p1_valid = 0;
            drain(5);
        end

        // Contention: both ports push twice back to back
        do_reset();
        drive(1'b0, 16'h0A00, 16'h0001, 1'b0, 1'b1);
        drive(1'b1, 16'h0B00, 16'h0002, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0A01, 16'h0003, 1'b1, 1'b0);
        drive(1'b1, 16'h0B01, 16'h0004, 1'b1, 1'b1);
        q_rr.push_back(mk(16'h0A00, 16'h0001, 1'b0, 1'b1, 2'b00));
        q_rr.push_back(mk(16'h0B00, 16'h0002, 1'b0, 1'b0, 2'b10));
        q_rr.push_back(mk(16'h0A01, 16'h0003, 1'b1, 1'b0, 2'b01));
        q_rr.push_back(mk(16'h0B01, 16'h0004, 1'b1, 1'b1, 2'b11));
        q_fp.push_back(mk(16'h0A00, 16'h0001, 1'b0, 1'b1, 2'b00));
        q_fp.push_back(mk(16'h0A01, 16'h0003, 1'b1, 1'b0, 2'b01));
        q_fp.push_back(mk(16'h0B00, 16'h0002, 1'b0, 1'b0, 2'b10));
        q_fp.push_back(mk(16'h0B01, 16'h0004, 1'b1, 1'b1, 2'b11));
        step();
        p0_valid = 0;
        p1_valid = 0;
        drain(10);

        // Hold with two queued entries on port 0
        do_reset();
        rq_hold = 1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 16'hC000 + 16'(i), 16'h7000 + 16'(i), 1'b0, 1'b1);
            expect_both(mk(16'hC000 + 16'(i), 16'h7000 + 16'(i), 1'b0, 1'b1, 2'(i)));
            step();
        end
        p0_valid = 0;
        chk("hold_full_ready", 36'({rr_p0_ready, fp_p0_ready}), 36'h0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_no_start", 36'({rr_rq_start, fp_rq_start}), 36'h0);
            step();
        end
        rq_hold = 0;
        #1;
        chk("hold_release_start", 36'({rr_rq_start, fp_rq_start}), 36'h3);
        drain(6);

        // Completion routing
        for (int i = 0; i < 4; i++) begin
            rs_wb = ctb[i].wb;
            rs_tag = ctb[i].tag;
            step();
            rs_wb = 0;
            rs_tag = 2'b00;
            chk("done_route_rr", 36'({rr_p0_done, rr_p1_done}), 36'({ctb[i].d0, ctb[i].d1}));
            chk("done_route_fp", 36'({fp_p0_done, fp_p1_done}), 36'({ctb[i].d0, ctb[i].d1}));
            if (ctb[i].d0) chk("done_seq_p0", 36'({rr_p0_done_seq, fp_p0_done_seq}), 36'({2{ctb[i].s0}}));
            if (ctb[i].d1) chk("done_seq_p1", 36'({rr_p1_done_seq, fp_p1_done_seq}), 36'({2{ctb[i].s1}}));
            step();
            chk("done_pulse_end", 36'({rr_p0_done, rr_p1_done, fp_p0_done, fp_p1_done}), 36'h0);
        end

        // FIFO boundary: third back-to-back push on port 1 is refused
        do_reset();
        rq_hold = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'hD000 + 16'(i), 16'h2000 + 16'(i), 1'b1, 1'b0);
            #1;
            chk("boundary_ready", 36'({rr_p1_ready, fp_p1_ready}), (i < 2) ? 36'h3 : 36'h0);
            if (i < 2) expect_both(mk(16'hD000 + 16'(i), 16'h2000 + 16'(i), 1'b1, 1'b0, {1'b1, 1'(i)}));
            step();
        end
        p1_valid = 0;
        rq_hold = 0;
        drain(6);

        // Reset mid-operation discards queued work
        do_reset();
        rq_hold = 1;
        drive(1'b0, 16'hE000, 16'h0, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'hE001, 16'h0, 1'b0, 1'b1);
        step();
        p0_valid = 0;
        #2;
        a_rst = 1'b0;
        rq_hold = 0;
        #1;
        chk("midreset_start", 36'({rr_rq_start, fp_rq_start}), 36'h0);
        chk("midreset_ready", 36'({rr_p0_ready, rr_p1_ready, fp_p0_ready, fp_p1_ready}), 36'hF);
        step();
        a_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midreset_quiet", 36'({rr_rq_start, fp_rq_start, rr_p0_done, rr_p1_done,
                                       fp_p0_done, fp_p1_done}), 36'h0);
        end
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 SHALL have parameter: PRIO_RR, 1, 1 = round-robin between ports, 0 = fixed priority to port 0.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: a_rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports, per requester n in {0,1}: pn_valid  in  1  request present.
REQ-005 SHALL have port: pn_ready  out  1  FIFO can accept request.
REQ-006 SHALL have port: pn_addr  in  16  memory address.
REQ-007 SHALL have port: pn_data  in  16  write data.
REQ-008 SHALL have port: pn_width  in  1  0 = 16-bit, 1 = 8-bit.
REQ-009 SHALL have port: pn_cmd  in  1  0 = read, 1 = write.
REQ-010 SHALL have port: pn_done  out  1  completion pulse for port n.
REQ-011 SHALL have port: pn_done_seq  out  1  sequence bit of the completed request.
REQ-012 SHALL have LSU-side ports: rq_addr out 16, rq_data out 16, rq_width out 1, rq_cmd out 1, rq_tag out 2, rq_start out 1.
REQ-013 SHALL have LSU-side inputs: rq_hold in 1 (LSU busy), rs_wb in 1 (completion), rs_tag in 2 (completed tag).

Function
REQ-014 SHALL give each port a 2-entry FIFO holding {addr, data, width, cmd, seq}.
REQ-015 SHALL assert pn_ready iff the port n FIFO count < 2, with no same-cycle pop bypass.
REQ-016 SHALL push on pn_valid & pn_ready at the clock edge.
REQ-017 SHALL make pushed entries eligible for issue no earlier than the next cycle.
REQ-018 SHALL drive rq_start combinationally as ~rq_hold & (FIFO0 non-empty | FIFO1 non-empty).
REQ-019 SHALL drive rq_addr, rq_data, rq_width and rq_cmd from the granted FIFO head.
REQ-020 SHALL pop the granted FIFO at the edge where rq_start = 1.
REQ-021 SHALL assert rq_start = 0 while rq_hold = 1, holding all FIFO and grant state.
REQ-022 SHALL grant the only non-empty port when exactly one FIFO is non-empty.
REQ-023 SHALL, when both FIFOs are non-empty and PRIO_RR = 1, grant the port not in last_grant.
REQ-024 SHALL, when both FIFOs are non-empty and PRIO_RR = 0, always grant port 0.
REQ-025 SHALL update last_grant only when rq_start = 1.
REQ-026 SHALL form rq_tag as {port index, entry seq}.
REQ-027 SHALL source each entry's seq from a per-port seq counter captured at push.
REQ-028 SHALL toggle the per-port seq counter on every push.
REQ-029 SHALL, on simultaneous push and pop on the same FIFO (count 1), leave count unchanged and keep order FIFO.
REQ-030 SHALL register completion: on rs_wb = 1, set p{rs_tag[1]}_done = 1 the next cycle for one cycle.
REQ-031 SHALL drive pn_done_seq = rs_tag[0] in that same cycle.
REQ-032 SHALL drive the done output of the other port to 0 in that cycle.
REQ-033 SHALL ignore rs_tag when rs_wb = 0.
REQ-034 SHALL hold rq_* data outputs stable and don't-care while rq_start = 0; verification checks them only when rq_start = 1.

Reset
REQ-035 SHALL, while a_rst = 0 (asynchronously), empty both FIFOs, giving p0_ready = p1_ready = 1 and rq_start = 0.
REQ-036 SHALL, on reset, clear seq counters to 0 and set last_grant = 1 so port 0 wins the first contention.
REQ-037 SHALL, on reset, clear p0_done, p1_done and both done_seq outputs to 0.
REQ-038 SHALL discard queued requests on reset mid-operation without issuing them.
REQ-039 SHALL not generate done pulses for discarded requests.

Verification
REQ-040 SHALL cover a single issue: p0 push addr 0x1234 write, rq_hold = 0 -> rq_start = 1 the next cycle with rq_addr = 0x1234, rq_cmd = 1, rq_tag = 2'b00, then FIFO0 empty.
REQ-041 SHALL cover contention (PRIO_RR = 1): both ports push in the same cycle, rq_hold = 0 -> issue order p0, p1, p0, ... with tags 00, 10, 01, 11; with PRIO_RR = 0 all p0 entries first.
REQ-042 SHALL cover hold: rq_hold = 1 for 5 cycles with 2 queued entries -> rq_start = 0 throughout, p0_ready = 0 when full, issue resumes the cycle rq_hold falls.
REQ-043 SHALL cover completion routing: rs_wb = 1, rs_tag = 2'b11 -> next cycle p1_done = 1, p1_done_seq = 1, p0_done = 0, then both 0.
REQ-044 SHALL cover FIFO boundary: 3 back-to-back p1_valid with rq_hold = 1 -> third not accepted (p1_ready = 0), the first two issue in order after release.
REQ-045 SHALL cover reset mid-operation: a_rst low with 2 entries queued -> immediate rq_start = 0, ready = 1, no later issue or done.
